// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: control inputs, instruction-memory request/response channel,
// and the iword handshake toward the decoder.
// master = fetch unit side, slave = environment (memory, decoder, branch unit).
interface fetch_unit_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        iword_valid;
  logic        iword_ready;
  logic [31:0] iword;
  logic [31:0] iword_pc;
  logic        fetch_misalign;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
    input  imem_rsp_data, iword_ready,
    output imem_req_valid, imem_addr, iword_valid, iword, iword_pc, fetch_misalign
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
    output imem_rsp_data, iword_ready,
    input  imem_req_valid, imem_addr, iword_valid, iword, iword_pc, fetch_misalign
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word requests, buffers returned words with
// their PCs in a small FIFO and hands them to the decoder over valid/ready.
// Redirects flush the buffer and mark all in-flight responses as stale.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect halts fetch and raises
// the sticky fetch_misalign flag; otherwise the low PC bits are simply cleared).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_CNT = cnt_t'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   out_pc_q, out_pc_d;
  logic [31:0]   buf_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  cnt_t          count_q, count_d;
  cnt_t          outstanding_q, outstanding_d;
  cnt_t          drop_q, drop_d;

  logic          run;
  logic [31:0]   target_pc;
  logic [CW:0]   credit_used;
  logic          req_valid;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          head_valid;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [0:0] {StRun, StHalt} state_e;
  state_e state_q, state_d;
  logic   misalign_q, misalign_d;

  assign target_pc = bus.redirect_pc;
  assign run       = (state_q == StRun);

  // Misaligned redirect parks fetch in StHalt until an aligned redirect arrives.
  always_comb begin
    state_d    = state_q;
    misalign_d = misalign_q;
    if (bus.redirect_valid) begin
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state_d    = StHalt;
        misalign_d = 1'b1;
      end else begin
        state_d    = StRun;
        misalign_d = 1'b0;
      end
    end
  end

  // Trap state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.fetch_misalign = misalign_q;
`else
  // Low bits are dropped so fetch always stays word aligned.
  assign target_pc          = bus.redirect_pc & ~32'h0000_0003;
  assign run                = 1'b1;
  assign bus.fetch_misalign = 1'b0;
`endif

  // Credits: buffered words plus live (non-stale) in-flight requests must fit the FIFO.
  assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q} - {1'b0, drop_q};
  assign req_valid   = run && bus.fetch_en && !bus.redirect_valid &&
                       (credit_used < {1'b0, DEPTH_CNT}) && (outstanding_q < DEPTH_CNT);
  assign req_fire    = req_valid && bus.imem_req_ready;
  assign head_valid  = (count_q != '0);
  assign pop         = head_valid && bus.iword_ready;
  assign push        = bus.imem_rsp_valid && (drop_q == '0) && !bus.redirect_valid;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.iword_valid    = head_valid;
  assign bus.iword          = head_valid ? buf_q[rd_ptr_q] : 32'h0;
  assign bus.iword_pc       = out_pc_q;

  // Next-state for PCs, FIFO pointers and request/drop counters; redirect wins.
  always_comb begin
    pc_d          = pc_q;
    out_pc_d      = out_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(bus.imem_rsp_valid);
    drop_d        = drop_q;

    if (bus.redirect_valid) begin
      pc_d     = target_pc;
      out_pc_d = target_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      // Everything still in flight after this cycle's response belongs to the old path.
      drop_d   = outstanding_q - cnt_t'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (pop) begin
        out_pc_d = out_pc_q + 32'd4;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      out_pc_q      <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      out_pc_q      <= out_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Instruction buffer storage; contents are masked by head_valid so no reset needed.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= bus.imem_rsp_data;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// checked against a queue-based model of the fetch stream.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned D        = 2;

  logic clk;
  logic rst;
  fetch_unit_if f ();

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int unsigned cyc; bit stale;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} word_t;

  pend_t       pend[$];     // requests accepted by memory, oldest first
  word_t       fifo_m[$];   // words the decoder should see, in order
  word_t       pop_log[$];  // DUT iword/iword_pc observed at each pop
  logic [31:0] exp_req_pc;
  bit          halted;
  bit          misalign_m;
  bit          nop_mode;
  int unsigned cyc;
  int unsigned req_count;
  int unsigned checks;
  int unsigned errors;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (nop_mode) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    fifo_m.delete();
    exp_req_pc = RESET_PC;
    halted     = 1'b0;
    misalign_m = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst              = 1'b1;
    f.fetch_en       = 1'b0;
    f.redirect_valid = 1'b0;
    f.redirect_pc    = 32'h0;
    f.imem_req_ready = 1'b0;
    f.imem_rsp_valid = 1'b0;
    f.imem_rsp_data  = 32'h0;
    f.iword_ready    = 1'b0;
    #1;
    chk("rst_req_valid", 32'(f.imem_req_valid), 32'h0);
    chk("rst_addr", f.imem_addr, RESET_PC);
    chk("rst_iword_valid", 32'(f.iword_valid), 32'h0);
    chk("rst_iword", f.iword, 32'h0);
    chk("rst_iword_pc", f.iword_pc, RESET_PC);
    chk("rst_misalign", 32'(f.fetch_misalign), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance the model by the
  // handshakes that the specification says complete on this edge.
  task automatic step(input bit fe, input bit redir, input logic [31:0] rpc,
                      input int unsigned rdy_pct, input int unsigned rsp_pct,
                      input int unsigned pop_pct);
    bit          rdy, rsp_ok, pop_r, exp_rv, req_fire, pop_fire;
    int unsigned live;
    pend_t       e;
    rdy    = ($urandom_range(99) < rdy_pct);
    rsp_ok = (pend.size() != 0) && (pend[0].cyc < cyc) && ($urandom_range(99) < rsp_pct);
    pop_r  = ($urandom_range(99) < pop_pct);
    f.fetch_en       = fe;
    f.redirect_valid = redir;
    f.redirect_pc    = rpc;
    f.imem_req_ready = rdy;
    f.imem_rsp_valid = rsp_ok;
    f.imem_rsp_data  = rsp_ok ? mem_word(pend[0].addr) : $urandom;
    f.iword_ready    = pop_r;
    #1;
    live = 0;
    foreach (pend[i]) if (!pend[i].stale) live++;
    exp_rv = !halted && fe && !redir && (fifo_m.size() + live < D) && (pend.size() < D);
    chk("req_valid", 32'(f.imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("imem_addr", f.imem_addr, exp_req_pc);
    chk("iword_valid", 32'(f.iword_valid), 32'(fifo_m.size() != 0));
    if (fifo_m.size() != 0) begin
      chk("iword", f.iword, fifo_m[0].data);
      chk("iword_pc", f.iword_pc, fifo_m[0].pc);
    end
    chk("misalign", 32'(f.fetch_misalign), 32'(misalign_m));
    req_fire = exp_rv && rdy;
    pop_fire = (fifo_m.size() != 0) && pop_r;
    if (pop_fire) pop_log.push_back('{pc: f.iword_pc, data: f.iword});
    @(posedge clk);
    if (pop_fire) void'(fifo_m.pop_front());
    if (rsp_ok) begin
      e = pend.pop_front();
      if (!e.stale && !redir) fifo_m.push_back('{pc: e.addr, data: mem_word(e.addr)});
    end
    if (req_fire) begin
      pend.push_back('{addr: exp_req_pc, cyc: cyc, stale: 1'b0});
      exp_req_pc = exp_req_pc + 32'd4;
      req_count++;
    end
    if (redir) begin
      fifo_m.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
`ifdef MISALIGN_TRAP_EN
      halted     = (rpc[1:0] != 2'b00);
      misalign_m = halted;
      exp_req_pc = rpc;
`else
      exp_req_pc = rpc & ~32'h3;
`endif
    end
    cyc++;
    @(negedge clk);
  endtask

  // Run with a fast memory and eager decoder until `want` pops are logged or budget ends.
  task automatic run_pops(input string tag, input int unsigned want, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (pop_log.size() < want && k < budget) begin
      step(1'b1, 1'b0, 32'h0, 100, 100, 100);
      k++;
    end
    chk(tag, pop_log.size(), want);
  endtask

  function automatic logic [31:0] log_pc(input int unsigned k);
    return (pop_log.size() > k) ? pop_log[k].pc : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] log_data(input int unsigned k);
    return (pop_log.size() > k) ? pop_log[k].data : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int unsigned fe_pct, rdy_pct, rsp_pct, pop_pct, n0;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    nop_mode = 1'b1;
    rst      = 1'b1;
    model_reset();

    // 1: sequential fetch of NOPs from address 0.
    do_reset();
    pop_log.delete();
    run_pops("t1_pops", 2, 20);
    chk("t1_pc0", log_pc(0), 32'h0);
    chk("t1_pc1", log_pc(1), 32'h4);
    chk("t1_data0", log_data(0), 32'h0000_0013);
    chk("t1_data1", log_data(1), 32'h0000_0013);
    nop_mode = 1'b0;

    // 2: stalled decoder limits requests to the buffer depth.
    do_reset();
    req_count = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 100, 100, 0);
    chk("t2_req_count", req_count, 2);
    chk("t2_req_held", 32'(f.imem_req_valid), 32'h0);
    step(1'b1, 1'b0, 32'h0, 100, 100, 100);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 100, 100, 0);
    chk("t2_req_resume", req_count, 3);

    // 3: redirect with two requests in flight drops both responses.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 100, 0, 0);
    step(1'b1, 1'b1, 32'h0000_0100, 100, 0, 0);
    pop_log.delete();
    run_pops("t3_pops", 1, 30);
    chk("t3_pc", log_pc(0), 32'h0000_0100);

    // 4: redirect coinciding with a response and a pop.
    do_reset();
    step(1'b1, 1'b0, 32'h0, 100, 0, 0);
    step(1'b0, 1'b0, 32'h0, 100, 100, 0);
    step(1'b1, 1'b0, 32'h0, 100, 0, 0);
    pop_log.delete();
    step(1'b1, 1'b1, 32'h0000_0400, 100, 100, 100);
    chk("t4_pop_done", pop_log.size(), 1);
    chk("t4_pop_pc", log_pc(0), 32'h0);
    f.redirect_valid = 1'b0;
    #1;
    chk("t4_flushed", 32'(f.iword_valid), 32'h0);
    pop_log.delete();
    run_pops("t4_pops", 1, 30);
    chk("t4_new_pc", log_pc(0), 32'h0000_0400);

    // 5: PC wraps from the top of the address space.
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 0, 0, 0);
    pop_log.delete();
    run_pops("t5_pops", 2, 30);
    chk("t5_pc0", log_pc(0), 32'hFFFF_FFFC);
    chk("t5_pc1", log_pc(1), 32'h0000_0000);

    // 6: misaligned redirect.
    do_reset();
`ifdef MISALIGN_TRAP_EN
    step(1'b1, 1'b1, 32'h0000_0102, 100, 100, 100);
    chk("t6_flag", 32'(f.fetch_misalign), 32'h1);
    n0 = req_count;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 100, 100, 100);
    chk("t6_no_req", req_count, n0);
    step(1'b1, 1'b1, 32'h0000_0200, 100, 100, 100);
    pop_log.delete();
    run_pops("t6_pops", 1, 30);
    chk("t6_pc", log_pc(0), 32'h0000_0200);
    chk("t6_flag_clr", 32'(f.fetch_misalign), 32'h0);
`else
    step(1'b1, 1'b1, 32'h0000_010E, 100, 100, 100);
    pop_log.delete();
    run_pops("t6_pops", 1, 30);
    chk("t6_pc", log_pc(0), 32'h0000_010C);
    chk("t6_flag", 32'(f.fetch_misalign), 32'h0);
`endif

    // Randomized traffic with occasional redirects and one mid-run reset.
    do_reset();
    for (int blk = 0; blk < 40; blk++) begin
      fe_pct  = $urandom_range(100, 20);
      rdy_pct = $urandom_range(100, 10);
      rsp_pct = $urandom_range(100, 10);
      pop_pct = $urandom_range(100, 0);
      if (blk == 20) do_reset();
      for (int i = 0; i < 50; i++) begin
        step(($urandom_range(99) < fe_pct), ($urandom_range(99) < 3), $urandom,
             rdy_pct, rsp_pct, pop_pct);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
